// File: rtl/serial_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

endpackage

// File: rtl/serial_comparator_bit_step.sv
// One MSB-first comparison step: does this bit pair decide, and which way.
module cmp_bit_step (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_sign,
  input  logic signed_mode,
  output logic differ,
  output logic a_less
);

  assign differ = a_bit ^ b_bit;
  // A set sign bit makes a two's-complement value smaller, so the sense flips.
  assign a_less = (is_sign && signed_mode) ? (a_bit & ~b_bit) : (~a_bit & b_bit);

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial lt/eq/gt comparator, one bit pair per cycle starting at the MSB.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             sm_r;
  logic [CW-1:0]    cnt;
  logic             found, found_less;
  cmp_result_t      res, res_fin;
  logic             differ, a_less;
  logic             last, accept, finish;

  cmp_bit_step u_step (
    .a_bit      (a_sh[WIDTH-1]),
    .b_bit      (b_sh[WIDTH-1]),
    .is_sign    (cnt == '0),
    .signed_mode(sm_r),
    .differ     (differ),
    .a_less     (a_less)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start && (state != COMPARE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = COMPARE;
      end
      COMPARE: begin
        busy = 1'b1;
        if (last || ((EARLY_EXIT != 0) && differ)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? COMPARE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result of the scan if it ends this cycle: an earlier decision wins over the current bit.
  always_comb begin
    res_fin    = '0;
    res_fin.eq = !(found || differ);
    res_fin.lt = found ? found_less  : (differ && a_less);
    res_fin.gt = found ? !found_less : (differ && !a_less);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      sm_r       <= 1'b0;
      cnt        <= '0;
      found      <= 1'b0;
      found_less <= 1'b0;
      res        <= '0;
    end else if (accept) begin
      a_sh       <= a;
      b_sh       <= b;
      sm_r       <= signed_mode;
      cnt        <= '0;
      found      <= 1'b0;
      found_less <= 1'b0;
      res        <= '0;
    end else if (state == COMPARE) begin
      a_sh <= a_sh << 1;
      b_sh <= b_sh << 1;
      if (!found && differ) begin
        found      <= 1'b1;
        found_less <= a_less;
      end
      // Counter parks at WIDTH-1 on the final bit, so it never wraps.
      if (finish) res <= res_fin;
      else        cnt <= cnt + CW'(1);
    end
  end

  assign lt = res.lt;
  assign eq = res.eq;
  assign gt = res.gt;

endmodule

// File: tb/tb_serial_comparator.sv
// Four comparator configurations driven side by side against a timeline model.
module tb_serial_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       sm = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] a3 = '0, b3 = '0;
  logic [3:0] busy, done, lt, eq, gt;

  int errors = 0;
  int checks = 0;

  // model state, one slot per instance: 0=W8/EE1 1=W8/EE0 2=W3/EE1 3=W3/EE0
  int         cyc = 0;
  bit         has [4];
  int         acc [4];
  int         dn  [4];
  logic [2:0] res [4];

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u8e (.clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(sm), .a(a8), .b(b8), .busy(busy[0]), .done(done[0]), .lt(lt[0]), .eq(eq[0]), .gt(gt[0]));
  serial_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u8f (.clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(sm), .a(a8), .b(b8), .busy(busy[1]), .done(done[1]), .lt(lt[1]), .eq(eq[1]), .gt(gt[1]));
  serial_comparator #(.WIDTH(3), .EARLY_EXIT(1)) u3e (.clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(sm), .a(a3), .b(b3), .busy(busy[2]), .done(done[2]), .lt(lt[2]), .eq(eq[2]), .gt(gt[2]));
  serial_comparator #(.WIDTH(3), .EARLY_EXIT(0)) u3f (.clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(sm), .a(a3), .b(b3), .busy(busy[3]), .done(done[3]), .lt(lt[3]), .eq(eq[3]), .gt(gt[3]));

  function automatic int wid(int i);
    return (i < 2) ? 8 : 3;
  endfunction

  function automatic bit early(int i);
    return (i == 0) || (i == 2);
  endfunction

  // {lt,eq,gt} from plain integer comparison of the interpreted operands
  function automatic logic [2:0] ref_res(int w, logic [31:0] a, logic [31:0] b, bit s);
    longint av, bv;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    return {av < bv, av == bv, av > bv};
  endfunction

  // cycles from accept to done: stop at the highest differing bit, else scan all
  function automatic int ref_lat(int w, bit ee, logic [31:0] a, logic [31:0] b);
    if (ee && (a != b))
      for (int p = w - 1; p >= 0; p--)
        if (a[p] != b[p]) return w - p;
    return w;
  endfunction

  function automatic logic [4:0] obs(int i);
    return {busy[i], done[i], lt[i], eq[i], gt[i]};
  endfunction

  function automatic logic [4:0] predict(int i);
    if (!has[i]) return 5'b0;
    return {(acc[i] <= cyc) && (cyc < dn[i]), cyc == dn[i], (cyc >= dn[i]) ? res[i] : 3'b000};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) has[i] = 1'b0;
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 4; i++) begin
        logic [31:0] av, bv;
        av = (i < 2) ? 32'(a8) : 32'(b3 & 3'b0) | 32'(a3);
        bv = (i < 2) ? 32'(b8) : 32'(b3);
        // a new request is taken unless the previous cycle was mid-scan
        if (start && !(has[i] && acc[i] <= cyc - 1 && cyc - 1 < dn[i])) begin
          has[i] = 1'b1;
          acc[i] = cyc;
          res[i] = ref_res(wid(i), av, bv, sm);
          dn[i]  = cyc + ref_lat(wid(i), early(i), av, bv);
        end
      end
    end
  end

  task automatic lit(string nm, int i, logic [4:0] exp);
    checks++;
    if (obs(i) !== exp) begin
      errors++;
      $display("FAIL %s: busy,done,lt,eq,gt got %b want %b", nm, obs(i), exp);
    end
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(int t);
    wait_cyc(t);
    @(negedge clk);
  endtask

  task automatic launch(logic [7:0] x8, logic [7:0] y8, logic [2:0] x3, logic [2:0] y3, bit s,
                        output int k);
    a8 = x8; b8 = y8; a3 = x3; b3 = y3; sm = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = cyc;
  endtask

  initial begin
    int k;
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (obs(i) !== predict(i)) begin
            errors++;
            if (errors < 30)
              $display("FAIL model cyc=%0d inst=%0d: busy,done,lt,eq,gt got %b want %b",
                       cyc, i, obs(i), predict(i));
          end
        end
      end
    join_none

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset_state", 0, 5'b00000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // unsigned 0x80 vs 0x7F: decided on the MSB
    launch(8'h80, 8'h7F, 3'd0, 3'd0, 1'b0, k);
    wait_neg(k);     lit("u80_busy", 0, 5'b10000);
    wait_neg(k + 1); lit("u80_done_gt", 0, 5'b01001);
    wait_neg(k + 2); lit("u80_held", 0, 5'b00001);
    wait_cyc(k + 9);

    // signed: -128 < 127
    launch(8'h80, 8'h7F, 3'd0, 3'd0, 1'b1, k);
    wait_neg(k + 1); lit("s80_done_lt", 0, 5'b01100);
    wait_cyc(k + 9);

    launch(8'h5A, 8'h5A, 3'd0, 3'd0, 1'b0, k);
    wait_neg(k + 7); lit("eq_busy_k7", 0, 5'b10000);
    wait_neg(k + 8); lit("eq_done_k8", 0, 5'b01010);
    wait_cyc(k + 9);

    launch(8'h01, 8'h03, 3'd0, 3'd0, 1'b0, k);
    wait_neg(k + 7); lit("ee0_busy_k7", 1, 5'b10000);
                     lit("ee1_done_k7", 0, 5'b01100);
    wait_neg(k + 8); lit("ee0_done_lt", 1, 5'b01100);
    wait_cyc(k + 9);

    // restart mid-scan is ignored; restart in the done cycle chains directly
    launch(8'h12, 8'h13, 3'd0, 3'd0, 1'b0, k);
    wait_cyc(k + 2);
    a8 = 8'hFF; b8 = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_neg(k + 8); lit("ignored_restart", 0, 5'b01100);
    #1;
    a8 = 8'hC0; b8 = 8'h40; sm = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);  lit("back_to_back", 0, 5'b10000);
    wait_neg(k + 10); lit("b2b_done_gt", 0, 5'b01001);
    wait_cyc(k + 20);

    // reset in the middle of a scan
    launch(8'h5A, 8'h5A, 3'd0, 3'd0, 1'b0, k);
    wait_cyc(k + 3);
    rst_n = 1'b0;
    #1 lit("async_reset", 0, 5'b00000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(cyc + 12);
    launch(8'h01, 8'h02, 3'd0, 3'd0, 1'b0, k);
    wait_neg(k + 7); lit("after_reset_lt", 0, 5'b01100);
    wait_cyc(k + 9);

    // exhaustive 3-bit, random 8-bit riding along
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 8; y++) begin
          launch(8'($urandom), 8'($urandom), 3'(x), 3'(y), s[0], k);
          wait_cyc(k + 9);
        end

    // random start traffic including back-to-back and ignored requests
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 2) == 0);
      sm = 1'($urandom);
      a8 = 8'($urandom); b8 = ($urandom_range(0, 3) == 0) ? a8 : 8'($urandom);
      a3 = 3'($urandom); b3 = 3'($urandom);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
